// File: rtl/line_memory_ctrl_if.sv
// Request/response bus between the dcache controller and the line memory.
// Handshake: the master raises enable_i with write_i/addr_i/data_i/be_i and holds
// enable_i high until ack_o; the slave samples the request on the accepting edge and
// answers with a single-cycle ack_o pulse. Only one request is outstanding at a time.
interface line_memory_ctrl_if #(
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
);
  logic                  enable_i;
  logic                  write_i;
  logic [31:0]           addr_i;
  logic [LINE_W-1:0]     data_i;
  logic [LINE_W/8-1:0]   be_i;
  logic                  ack_o;
  logic [LINE_W-1:0]     data_o;
  logic                  err_o;
  logic [CNT_W-1:0]      rd_count_o;
  logic [CNT_W-1:0]      wr_count_o;

  modport master (
    output enable_i, write_i, addr_i, data_i, be_i,
    input  ack_o, data_o, err_o, rd_count_o, wr_count_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i, be_i,
    output ack_o, data_o, err_o, rd_count_o, wr_count_o
  );
endinterface

// File: rtl/line_memory_ctrl.sv
// Parametrised off-chip line memory: fixed-latency single-request access with
// per-byte write enables, out-of-range detection and saturating access counters.
module line_memory_ctrl #(
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int CNT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  line_memory_ctrl_if.slave   mem,
  output logic [1:0]          state_o
);

  localparam int BE_W  = LINE_W / 8;
  localparam int OFS   = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [7:0]       LAT      = 8'(LATENCY);
  localparam logic [31:0]      OFS_MASK = (32'd1 << OFS) - 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]        state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic              err_q;
  logic [LINE_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [LINE_W-1:0] rdata_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [LINE_W-1:0] mem_q [DEPTH];

  logic              in_err;
  logic [IDX_W-1:0]  in_idx;
  logic              enter_ack;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_write;
  logic              cur_err;
  logic [LINE_W-1:0] cur_data;
  logic [BE_W-1:0]   cur_be;

  // Decode the live address: index bits above the offset, reject high bits or misalignment
  always_comb begin
    in_idx = mem.addr_i[OFS +: IDX_W];
    in_err = ((mem.addr_i >> (OFS + IDX_W)) != 32'd0) || ((mem.addr_i & OFS_MASK) != 32'd0);
  end

  // Request being completed: live inputs on the accept edge (needed when LATENCY=1 jumps
  // straight to ACK), latched copy afterwards
  always_comb begin
    cur_idx   = idx_q;
    cur_write = write_q;
    cur_err   = err_q;
    cur_data  = wdata_q;
    cur_be    = be_q;
    if (state_q == S_IDLE) begin
      cur_idx   = in_idx;
      cur_write = mem.write_i;
      cur_err   = in_err;
      cur_data  = mem.data_i;
      cur_be    = mem.be_i;
    end
  end

  // Next state: wait counter counts edges since accept (accept edge = 1), ACK entered when it hits LATENCY
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (mem.enable_i) begin
          wait_d  = 8'd1;
          state_d = (LAT == 8'd1) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        wait_d = wait_q + 8'd1;
        if (wait_d == LAT) state_d = S_ACK;
      end
      S_ACK: begin
        wait_d  = 8'd0;
        state_d = S_IDLE;
      end
      default: begin
        wait_d  = 8'd0;
        state_d = S_IDLE;
      end
    endcase
    enter_ack = (state_d == S_ACK) && (state_q != S_ACK);
  end

  // FSM, request latch, read data register and saturating counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      wait_q   <= 8'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_IDLE && mem.enable_i) begin
        idx_q   <= in_idx;
        write_q <= mem.write_i;
        err_q   <= in_err;
        wdata_q <= mem.data_i;
        be_q    <= mem.be_i;
      end
      // data_o is only non-zero during the ACK cycle of an in-range read
      if (enter_ack && !cur_write && !cur_err) rdata_q <= mem_q[cur_idx];
      else                                     rdata_q <= '0;
      if (state_q == S_ACK && !err_q) begin
        if (write_q) begin
          if (wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + 1'b1;
        end else begin
          if (rd_cnt_q != CNT_MAX) rd_cnt_q <= rd_cnt_q + 1'b1;
        end
      end
    end
  end

  // Memory array is never cleared; writes commit on the edge entering ACK unless reset is held
  always_ff @(posedge clk_i) begin
    if (rst_i && enter_ack && cur_write && !cur_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (cur_be[b]) mem_q[cur_idx][b*8 +: 8] <= cur_data[b*8 +: 8];
      end
    end
  end

  assign mem.ack_o      = (state_q == S_ACK);
  assign mem.err_o      = (state_q == S_ACK) && err_q;
  assign mem.data_o     = rdata_q;
  assign mem.rd_count_o = rd_cnt_q;
  assign mem.wr_count_o = wr_cnt_q;
  assign state_o        = state_q;

endmodule
